// File: rtl/sdram_port_arbiter.sv
// Two-port (fetch/data) round-robin arbiter in front of an SDRAM controller.
// One transaction in flight; registered strobes, acks and read data.
module sdram_port_arbiter #(
  parameter int ADDR_WIDTH     = 22,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    sync_reset,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_ack,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_ack,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_waitrequest,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_rdatavalid,
  output logic                    timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WAIT_RD,
    DONE
  } state_t;

  state_t        state;
  logic          grant_d;
  logic          last_d;
  logic [CW-1:0] tcnt;
  logic          pick_d;

  // Data wins only if fetch is idle or fetch was served last.
  always_comb begin
    pick_d = d_req && (!i_req || !last_d);
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state       <= IDLE;
      grant_d     <= 1'b0;
      last_d      <= 1'b1;
      tcnt        <= '0;
      i_ack       <= 1'b0;
      d_ack       <= 1'b0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      timeout_err <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_req || d_req) begin
            grant_d   <= pick_d;
            last_d    <= pick_d;
            mem_addr  <= pick_d ? d_addr : i_addr;
            mem_wdata <= pick_d ? d_wdata : '0;
            mem_be    <= pick_d ? d_be : '0;
            mem_write <= pick_d & d_we;
            mem_read  <= !(pick_d & d_we);
            state     <= CMD;
          end
        end
        CMD: begin
          if (!mem_waitrequest) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (mem_write) begin
              d_ack <= 1'b1;
              state <= DONE;
            end else begin
              tcnt  <= '0;
              state <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          if (mem_rdatavalid) begin
            if (grant_d) begin
              d_rdata <= mem_rdata;
              d_ack   <= 1'b1;
            end else begin
              i_rdata <= mem_rdata;
              i_ack   <= 1'b1;
            end
            state <= DONE;
          end else if (tcnt == T_LAST) begin
            if (grant_d) begin
              d_rdata <= '0;
              d_ack   <= 1'b1;
            end else begin
              i_rdata <= '0;
              i_ack   <= 1'b1;
            end
            timeout_err <= 1'b1;
            state       <= DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter with a behavioural SDRAM responder.
// Responder and requesters are driven at the falling edge.
module tb_sdram_port_arbiter;

  localparam int AW = 22;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 20;

  logic          clk;
  logic          sync_reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_be;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_waitrequest;
  logic [DW-1:0] mem_rdata;
  logic          mem_rdatavalid;
  logic          timeout_err;

  sdram_port_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .sync_reset(sync_reset),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_ack(i_ack),
    .i_rdata(i_rdata),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_be(d_be),
    .d_ack(d_ack),
    .d_rdata(d_rdata),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be(mem_be),
    .mem_waitrequest(mem_waitrequest),
    .mem_rdata(mem_rdata),
    .mem_rdatavalid(mem_rdatavalid),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic          d;
    logic [DW-1:0] rdata;
    int            cyc;
  } ack_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    int            cyc;
  } cmd_t;

  ack_t obs_ack[$];
  ack_t exp_ack[$];
  cmd_t obs_cmd[$];
  cmd_t exp_cmd[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int strobe_cycles = 0;
  int wait_left = 0;
  int rd_cnt = 0;
  int rd_delay = 1;
  bit rd_never = 0;
  bit rd_fixed_en = 0;
  bit keep_req = 0;
  logic [DW-1:0] rd_fixed = '0;
  logic [DW-1:0] rd_next = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: observe outputs, then drive requesters and responder.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (i_ack) begin
      obs_ack.push_back('{1'b0, i_rdata, cyc});
      if (!keep_req) i_req = 1'b0;
    end
    if (d_ack) begin
      obs_ack.push_back('{1'b1, d_rdata, cyc});
      if (!keep_req) d_req = 1'b0;
    end
    mem_rdatavalid = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        mem_rdatavalid = 1'b1;
        mem_rdata = rd_next;
      end
    end
    if (mem_read || mem_write) begin
      strobe_cycles++;
      mem_waitrequest = (wait_left > 0);
      if (wait_left > 0) begin
        wait_left--;
      end else begin
        obs_cmd.push_back('{mem_write, mem_addr,
                            mem_wdata, mem_be, cyc});
        if (mem_read && !rd_never) begin
          rd_cnt = rd_delay;
          rd_next = rd_fixed_en ? rd_fixed
                                : {10'h2A5, mem_addr};
        end
      end
    end else begin
      mem_waitrequest = 1'b0;
    end
  endtask

  task automatic do_reset();
    sync_reset = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    rd_cnt = 0;
    wait_left = 0;
    step();
    step();
    sync_reset = 1'b0;
    obs_ack.delete();
    obs_cmd.delete();
    exp_ack.delete();
    exp_cmd.delete();
  endtask

  task automatic test_reset();
    sync_reset = 1'b1;
    step();
    step();
    sync_reset = 1'b0;
    step();
    n_cmp++;
    if ({i_ack, d_ack, mem_read, mem_write} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_strobes: got %b want 0000",
               {i_ack, d_ack, mem_read, mem_write});
    end
    n_cmp++;
    if (i_rdata !== '0 || d_rdata !== '0) begin
      n_bad++;
      $display("FAIL reset_rdata: got %h/%h want 0/0",
               i_rdata, d_rdata);
    end
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_timeout_err: got %b want 0",
               timeout_err);
    end
    obs_ack.delete();
    obs_cmd.delete();
  endtask

  task automatic test_fetch_read();
    int s0;
    int rc;
    ack_t a;
    ack_t ea;
    cmd_t c;
    cmd_t ec;
    rd_fixed_en = 1;
    rd_fixed = 32'hDEADBEEF;
    rd_delay = 3;
    rd_never = 0;
    wait_left = 0;
    s0 = strobe_cycles;
    i_addr = 22'h000100;
    i_req = 1'b1;
    rc = cyc;
    exp_cmd.push_back('{1'b0, 22'h000100, '0, '0, rc + 1});
    exp_ack.push_back('{1'b0, 32'hDEADBEEF, rc + 5});
    for (int k = 0; k < 40 && obs_ack.size() == 0; k++)
      step();
    repeat (3) step();
    n_cmp++;
    if (strobe_cycles - s0 != 1) begin
      n_bad++;
      $display("FAIL fetch_read_cycles: got %0d want 1",
               strobe_cycles - s0);
    end
    ec = exp_cmd.pop_front();
    n_cmp++;
    if (obs_cmd.size() != 1) begin
      n_bad++;
      $display("FAIL fetch_cmd_count: got %0d want 1",
               obs_cmd.size());
    end else begin
      c = obs_cmd.pop_front();
      n_cmp++;
      if (c.we !== ec.we || c.addr !== ec.addr ||
          c.cyc != ec.cyc) begin
        n_bad++;
        $display("FAIL fetch_cmd: got we=%b a=%h c=%0d want %b %h %0d",
                 c.we, c.addr, c.cyc, ec.we, ec.addr, ec.cyc);
      end
    end
    ea = exp_ack.pop_front();
    n_cmp++;
    if (obs_ack.size() != 1) begin
      n_bad++;
      $display("FAIL fetch_ack_count: got %0d want 1",
               obs_ack.size());
    end else begin
      a = obs_ack.pop_front();
      n_cmp++;
      if (a.d !== ea.d || a.rdata !== ea.rdata ||
          a.cyc != ea.cyc) begin
        n_bad++;
        $display("FAIL fetch_ack: got d=%b %h c=%0d want %b %h %0d",
                 a.d, a.rdata, a.cyc, ea.d, ea.rdata, ea.cyc);
      end
    end
    n_cmp++;
    if (i_rdata !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL fetch_rdata_hold: got %h want deadbeef",
               i_rdata);
    end
    obs_ack.delete();
    obs_cmd.delete();
  endtask

  task automatic test_data_write();
    int s0;
    int rc;
    ack_t a;
    ack_t ea;
    cmd_t c;
    cmd_t ec;
    rd_fixed_en = 0;
    d_we = 1'b1;
    d_addr = 22'h3FFFFF;
    d_wdata = 32'h12345678;
    d_be = 4'hC;
    wait_left = 4;
    s0 = strobe_cycles;
    d_req = 1'b1;
    rc = cyc;
    exp_cmd.push_back('{1'b1, 22'h3FFFFF, 32'h12345678,
                        4'hC, rc + 5});
    exp_ack.push_back('{1'b1, 32'h0, rc + 6});
    for (int k = 0; k < 40 && obs_ack.size() == 0; k++) begin
      step();
      if (mem_write) begin
        n_cmp++;
        if (mem_addr !== 22'h3FFFFF ||
            mem_wdata !== 32'h12345678 ||
            mem_be !== 4'hC || mem_read !== 1'b0) begin
          n_bad++;
          $display("FAIL write_stable: got %h %h %h want 3fffff 12345678 c",
                   mem_addr, mem_wdata, mem_be);
        end
        d_addr = d_addr - 1'b1;
        d_wdata = ~d_wdata;
        d_be = ~d_be;
      end
    end
    step();
    n_cmp++;
    if (strobe_cycles - s0 != 5) begin
      n_bad++;
      $display("FAIL write_cycles: got %0d want 5",
               strobe_cycles - s0);
    end
    ec = exp_cmd.pop_front();
    n_cmp++;
    if (obs_cmd.size() != 1) begin
      n_bad++;
      $display("FAIL write_cmd_count: got %0d want 1",
               obs_cmd.size());
    end else begin
      c = obs_cmd.pop_front();
      n_cmp++;
      if (c.we !== ec.we || c.addr !== ec.addr ||
          c.wdata !== ec.wdata || c.be !== ec.be ||
          c.cyc != ec.cyc) begin
        n_bad++;
        $display("FAIL write_cmd: got %b %h %h %h c=%0d want cyc %0d",
                 c.we, c.addr, c.wdata, c.be, c.cyc, ec.cyc);
      end
    end
    ea = exp_ack.pop_front();
    n_cmp++;
    if (obs_ack.size() != 1) begin
      n_bad++;
      $display("FAIL write_ack_count: got %0d want 1",
               obs_ack.size());
    end else begin
      a = obs_ack.pop_front();
      n_cmp++;
      if (a.d !== ea.d || a.rdata !== ea.rdata ||
          a.cyc != ea.cyc) begin
        n_bad++;
        $display("FAIL write_ack: got d=%b %h c=%0d want %b %h %0d",
                 a.d, a.rdata, a.cyc, ea.d, ea.rdata, ea.cyc);
      end
    end
    d_we = 1'b0;
    obs_ack.delete();
    obs_cmd.delete();
  endtask

  task automatic test_round_robin();
    ack_t a;
    ack_t ea;
    sync_reset = 1'b1;
    rd_cnt = 0;
    step();
    rd_fixed_en = 0;
    rd_delay = 2;
    keep_req = 1;
    i_addr = 22'h000200;
    d_addr = 22'h000300;
    d_we = 1'b0;
    i_req = 1'b1;
    d_req = 1'b1;
    step();
    sync_reset = 1'b0;
    obs_ack.delete();
    obs_cmd.delete();
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0)
        exp_ack.push_back('{1'b0, {10'h2A5, 22'h000200}, 0});
      else
        exp_ack.push_back('{1'b1, {10'h2A5, 22'h000300}, 0});
    end
    for (int k = 0; k < 200 && obs_ack.size() < 8; k++) begin
      step();
      if (obs_ack.size() >= 8) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    keep_req = 0;
    repeat (6) step();
    n_cmp++;
    if (obs_ack.size() != 8) begin
      n_bad++;
      $display("FAIL rr_ack_count: got %0d want 8",
               obs_ack.size());
    end
    for (int k = 0; k < 8; k++) begin
      ea = exp_ack.pop_front();
      if (obs_ack.size() > 0) begin
        a = obs_ack.pop_front();
        n_cmp++;
        if (a.d !== ea.d || a.rdata !== ea.rdata) begin
          n_bad++;
          $display("FAIL rr_grant_%0d: got d=%b %h want %b %h",
                   k, a.d, a.rdata, ea.d, ea.rdata);
        end
      end
    end
    n_cmp++;
    if (i_rdata !== {10'h2A5, 22'h000200} ||
        d_rdata !== {10'h2A5, 22'h000300}) begin
      n_bad++;
      $display("FAIL rr_rdata_hold: got %h/%h want %h/%h",
               i_rdata, d_rdata, {10'h2A5, 22'h000200},
               {10'h2A5, 22'h000300});
    end
    obs_ack.delete();
    obs_cmd.delete();
    exp_ack.delete();
  endtask

  task automatic test_timeout();
    ack_t a;
    ack_t ea;
    cmd_t c;
    int want_cyc;
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL to_pre: got %b want 0", timeout_err);
    end
    rd_never = 1;
    d_we = 1'b0;
    d_addr = 22'h0ABCDE;
    d_req = 1'b1;
    exp_ack.push_back('{1'b1, 32'h0, 0});
    for (int k = 0; k < TO + 40 && obs_ack.size() == 0; k++)
      step();
    step();
    want_cyc = -1;
    if (obs_cmd.size() > 0) begin
      c = obs_cmd.pop_front();
      want_cyc = c.cyc + TO + 1;
    end
    ea = exp_ack.pop_front();
    n_cmp++;
    if (obs_ack.size() != 1) begin
      n_bad++;
      $display("FAIL to_ack_count: got %0d want 1",
               obs_ack.size());
    end else begin
      a = obs_ack.pop_front();
      n_cmp++;
      if (a.d !== ea.d || a.rdata !== ea.rdata ||
          a.cyc != want_cyc) begin
        n_bad++;
        $display("FAIL to_ack: got d=%b %h c=%0d want %b %h %0d",
                 a.d, a.rdata, a.cyc, ea.d, ea.rdata, want_cyc);
      end
    end
    n_cmp++;
    if (timeout_err !== 1'b1) begin
      n_bad++;
      $display("FAIL to_flag: got %b want 1", timeout_err);
    end
    rd_never = 0;
    rd_delay = 1;
    i_addr = 22'h000010;
    i_req = 1'b1;
    obs_ack.delete();
    obs_cmd.delete();
    for (int k = 0; k < 40 && obs_ack.size() == 0; k++)
      step();
    n_cmp++;
    if (obs_ack.size() != 1 ||
        i_rdata !== {10'h2A5, 22'h000010}) begin
      n_bad++;
      $display("FAIL to_next_read: got n=%0d %h want 1 %h",
               obs_ack.size(), i_rdata, {10'h2A5, 22'h000010});
    end
    n_cmp++;
    if (timeout_err !== 1'b1) begin
      n_bad++;
      $display("FAIL to_sticky: got %b want 1", timeout_err);
    end
    step();
    do_reset();
    step();
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL to_clear: got %b want 0", timeout_err);
    end
  endtask

  task automatic test_reset_abort();
    int rc;
    do_reset();
    rd_delay = 3;
    i_addr = 22'h000040;
    i_req = 1'b1;
    for (int k = 0; k < 20 && obs_cmd.size() == 0; k++)
      step();
    step();
    sync_reset = 1'b1;
    i_req = 1'b0;
    step();
    sync_reset = 1'b0;
    repeat (8) step();
    n_cmp++;
    if (obs_cmd.size() != 1 || obs_ack.size() != 0) begin
      n_bad++;
      $display("FAIL abort_ack: got cmd=%0d ack=%0d want 1 0",
               obs_cmd.size(), obs_ack.size());
    end
    n_cmp++;
    if (i_rdata !== '0 || d_rdata !== '0 ||
        mem_read !== 1'b0 || mem_write !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_state: got %h %h %b%b want 0 0 00",
               i_rdata, d_rdata, mem_read, mem_write);
    end
    obs_cmd.delete();
    obs_ack.delete();
    d_we = 1'b1;
    d_addr = 22'h000777;
    d_wdata = 32'hCAFEF00D;
    d_be = 4'hF;
    d_req = 1'b1;
    rc = cyc;
    exp_ack.push_back('{1'b1, 32'h0, rc + 2});
    for (int k = 0; k < 20 && obs_ack.size() == 0; k++)
      step();
    step();
    n_cmp++;
    if (obs_ack.size() != 1 || obs_ack[0].cyc != rc + 2 ||
        obs_ack[0].d !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_idle_write: got n=%0d want ack at %0d",
               obs_ack.size(), rc + 2);
    end
    d_we = 1'b0;
    obs_ack.delete();
    obs_cmd.delete();
    exp_ack.delete();
  endtask

  task automatic test_spurious();
    int s0;
    s0 = strobe_cycles;
    rd_next = 32'h5555AAAA;
    rd_cnt = 1;
    repeat (6) step();
    n_cmp++;
    if (obs_ack.size() != 0 || strobe_cycles != s0) begin
      n_bad++;
      $display("FAIL spurious_ack: got ack=%0d strobes=%0d want 0 0",
               obs_ack.size(), strobe_cycles - s0);
    end
    n_cmp++;
    if (i_rdata !== '0 || d_rdata !== '0 ||
        timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL spurious_out: got %h %h %b want 0 0 0",
               i_rdata, d_rdata, timeout_err);
    end
  endtask

  initial begin
    sync_reset = 1'b1;
    i_req = 1'b0;
    i_addr = '0;
    d_req = 1'b0;
    d_we = 1'b0;
    d_addr = '0;
    d_wdata = '0;
    d_be = '0;
    mem_waitrequest = 1'b0;
    mem_rdata = '0;
    mem_rdatavalid = 1'b0;
    test_reset();
    test_fetch_read();
    test_data_write();
    test_round_robin();
    test_timeout();
    test_reset_abort();
    test_spurious();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
